// File: rtl/counter_pkg.sv
// Shared types and constants for the counter run/stop/step sequencer.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CNT_W_DEFAULT = 3;
    localparam int SIM_PRESCALE  = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..PRESCALE-1 divider; tick is high in the last cycle of each period.
module tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int              PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_reg;

    // A held prescaler never ticks, so a frozen wrap is deferred rather than lost.
    assign tick = !hold && (ps_reg == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_reg <= '0;
        end else if (clr) begin
            ps_reg <= '0;
        end else if (!hold) begin
            ps_reg <= (ps_reg == LAST) ? '0 : ps_reg + 1'b1;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Run/stop/single-step sequencer producing registered clear/enable strobes for the counter.
// Optional build macro COUNTER_CTRL_AUTORELOAD_EN: one-shot limit clears and keeps running.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int PRESCALE = 100000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             dir,
    input  logic             one_shot,
    input  logic [CNT_W-1:0] limit,
    input  logic [CNT_W-1:0] count,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    state_t           state_reg, state_next;
    logic             dir_reg, one_shot_reg;
    logic [CNT_W-1:0] limit_reg;
    logic             clr_reg, clr_next;
    logic             en_reg, en_next;
    logic             done_reg, done_next;
    logic             busy_reg, busy_next;
    logic             latch_cfg;
    logic             ps_clr, ps_hold, tick;
    logic             at_limit;

    // Prescaler controls depend only on state and commands, never on tick.
    assign ps_hold = !((state_reg == RUN) && !stop);
    assign ps_clr  = start && ((state_reg == IDLE) || ((state_reg == DONE) && !stop));

    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (ps_clr),
        .hold  (ps_hold),
        .tick  (tick)
    );

    assign at_limit = one_shot_reg && (count == limit_reg);

    always_comb begin
        state_next = state_reg;
        clr_next   = 1'b0;
        en_next    = 1'b0;
        done_next  = 1'b0;
        latch_cfg  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    latch_cfg  = 1'b1;
                    clr_next   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = PAUSE;
                end else if (tick) begin
                    if (at_limit) begin
                        done_next = 1'b1;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
                        clr_next  = 1'b1;
`else
                        state_next = DONE;
`endif
                    end else begin
                        en_next = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (start) begin
                    state_next = RUN;
                end else if (step) begin
                    if (at_limit) begin
                        done_next = 1'b1;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
                        clr_next  = 1'b1;
`else
                        state_next = DONE;
`endif
                    end else begin
                        en_next = 1'b1;
                    end
                end
            end
            DONE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (start) begin
                    latch_cfg  = 1'b1;
                    clr_next   = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next == RUN) || (state_next == PAUSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            dir_reg      <= 1'b0;
            one_shot_reg <= 1'b0;
            limit_reg    <= '0;
            clr_reg      <= 1'b0;
            en_reg       <= 1'b0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            clr_reg   <= clr_next;
            en_reg    <= en_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
            if (latch_cfg) begin
                dir_reg      <= dir;
                one_shot_reg <= one_shot;
                limit_reg    <= limit;
            end
        end
    end

    assign cnt_clr = clr_reg;
    assign cnt_en  = en_reg;
    assign cnt_up  = dir_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign state   = state_reg;

endmodule
